// File: rtl/avalon_st_packet_fifo_if.sv
// Avalon-ST sink/source bundle for avalon_st_packet_fifo.
// slave = the FIFO side, master = the driver/monitor side.
interface avalon_st_packet_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  asi_valid;
   logic [DATA_WIDTH-1:0] asi_data;
   logic                  asi_startofpacket;
   logic                  asi_endofpacket;
   logic                  asi_ready;
   logic                  aso_valid;
   logic [DATA_WIDTH-1:0] aso_data;
   logic                  aso_startofpacket;
   logic                  aso_endofpacket;
   logic                  aso_ready;

   modport slave (
      input  asi_valid, asi_data, asi_startofpacket, asi_endofpacket,
      output asi_ready,
      output aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
      input  aso_ready
   );

   modport master (
      output asi_valid, asi_data, asi_startofpacket, asi_endofpacket,
      input  asi_ready,
      input  aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
      output aso_ready
   );
endinterface

// File: rtl/avalon_st_packet_fifo.sv
// Avalon-ST packet FIFO with sop/eop sideband, fill level and framing check.
// Define AVST_PKT_FIFO_STORE_FORWARD_EN for store-and-forward presentation.
module avalon_st_packet_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int ALMOST_FULL = DEPTH - 4,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   avalon_st_packet_fifo_if.slave    st,
   output logic [CW-1:0]             fill_level,
   output logic                      almost_full,
   output logic                      protocol_error
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AF   = CW'(ALMOST_FULL);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          in_pkt_q, in_pkt_d;
   logic          err_q, err_d;
   logic          af_q;
   logic          push, pop, avail;
   logic [EW-1:0] head;

   assign head = mem_q[rd_ptr_q];

   assign st.asi_ready         = !reset && (count_q < FULL);
   assign st.aso_valid         = !reset && avail;
   assign st.aso_data          = head[DATA_WIDTH-1:0];
   assign st.aso_endofpacket   = head[DATA_WIDTH];
   assign st.aso_startofpacket = head[DATA_WIDTH+1];

   assign push = st.asi_valid && st.asi_ready;
   assign pop  = st.aso_valid && st.aso_ready;

   assign fill_level     = count_q;
   assign almost_full    = af_q;
   assign protocol_error = err_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Framing violations are flagged but the beat is still stored.
   always_comb begin
      in_pkt_d = in_pkt_q;
      err_d    = err_q;
      if (push) begin
         if (st.asi_startofpacket == in_pkt_q)
            err_d = 1'b1;
         if (st.asi_endofpacket)
            in_pkt_d = 1'b0;
         else if (st.asi_startofpacket)
            in_pkt_d = 1'b1;
      end
   end

`ifdef AVST_PKT_FIFO_STORE_FORWARD_EN
   logic [CW-1:0] pkt_q, pkt_d;
   logic          drain_q, drain_d;

   always_comb begin
      pkt_d = pkt_q;
      unique case ({push && st.asi_endofpacket, pop && st.aso_endofpacket})
         2'b10:   pkt_d = pkt_q + CW'(1);
         2'b01:   pkt_d = pkt_q - CW'(1);
         default: pkt_d = pkt_q;
      endcase
   end

   // Keep streaming a packet once its head beat has left the FIFO.
   assign drain_d = pop ? !st.aso_endofpacket : drain_q;
   assign avail   = (count_q != '0) &&
                    ((pkt_q != '0) || (count_q == FULL) || drain_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         pkt_q   <= pkt_d;
         drain_q <= drain_d;
      end
   end
`else
   assign avail = (count_q != '0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         in_pkt_q <= 1'b0;
         err_q    <= 1'b0;
         af_q     <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q  <= count_d;
         in_pkt_q <= in_pkt_d;
         err_q    <= err_d;
         af_q     <= (count_d >= AF);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {st.asi_startofpacket, st.asi_endofpacket,
                             st.asi_data};
   end
endmodule

// File: tb/tb_avalon_st_packet_fifo.sv
// Self-checking bench for avalon_st_packet_fifo (DATA_WIDTH=32, DEPTH=16).
// Reference model: beat queue, count and framing tracker.
module tb_avalon_st_packet_fifo;
   localparam int DW = 32;
   localparam int DEPTH = 16;
   localparam int AF = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   avalon_st_packet_fifo_if #(.DATA_WIDTH(DW)) st ();
   logic [4:0] fill_level;
   logic       almost_full;
   logic       protocol_error;

   avalon_st_packet_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .st             (st),
      .fill_level     (fill_level),
      .almost_full    (almost_full),
      .protocol_error (protocol_error)
   );

   typedef struct {
      bit          v;
      logic [31:0] d;
      bit          sop;
      bit          eop;
      bit          rdy;
      bit          exp_err;
      int          exp_fill;
   } vec_t;

   int errors = 0;
   int checks = 0;
   logic [DW+1:0] q[$];
   int mcount, mpkt;
   bit merr, min, maf, mdrain;
   int obs_fill;
   bit obs_err;
   vec_t tv[$];

   function automatic bit mvalid();
`ifdef AVST_PKT_FIFO_STORE_FORWARD_EN
      return mcount > 0 && (mpkt > 0 || mcount == DEPTH || mdrain);
`else
      return mcount > 0;
`endif
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mcount = 0;
      mpkt = 0;
      merr = 0;
      min = 0;
      maf = 0;
      mdrain = 0;
   endtask

   task automatic step(bit v, logic [DW-1:0] d, bit sop, bit eop, bit rdy);
      bit push, pop;
      logic [DW+1:0] e;
      st.asi_valid = v;
      st.asi_data = d;
      st.asi_startofpacket = sop;
      st.asi_endofpacket = eop;
      st.aso_ready = rdy;
      @(negedge clk);
      chk("asi_ready", st.asi_ready, mcount < DEPTH);
      chk("aso_valid", st.aso_valid, mvalid());
      if (mvalid())
         chk("aso_beat", {st.aso_startofpacket, st.aso_endofpacket,
                          st.aso_data}, q[0]);
      chk("fill_level", fill_level, mcount);
      chk("almost_full", almost_full, maf);
      chk("protocol_error", protocol_error, merr);
      obs_fill = fill_level;
      obs_err = protocol_error;
      push = v && (mcount < DEPTH);
      pop = mvalid() && rdy;
      if (pop) begin
         e = q.pop_front();
         if (e[DW]) mpkt--;
         mdrain = !e[DW];
      end
      if (push) begin
         q.push_back({sop, eop, d});
         if (eop) mpkt++;
         if ((!min && !sop) || (min && sop)) merr = 1;
         min = eop ? 1'b0 : (sop ? 1'b1 : min);
      end
      mcount = mcount + int'(push) - int'(pop);
      maf = mcount >= AF;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 200 && mcount > 0; i++)
         step(0, '0, 0, 0, 1);
      checks++;
      if (mcount != 0) begin
         errors++;
         $display("FAIL %s_timeout: left %0d required 0", name, mcount);
      end
   endtask

   task automatic run_table(string name);
      foreach (tv[i]) begin
         step(tv[i].v, tv[i].d, tv[i].sop, tv[i].eop, tv[i].rdy);
         chk({name, "_err"}, obs_err, tv[i].exp_err);
         if (tv[i].exp_fill >= 0)
            chk({name, "_fill"}, obs_fill, tv[i].exp_fill);
      end
   endtask

   initial begin
      int sent;
      bit acc;
      reset = 1'b1;
      st.asi_valid = 0;
      st.asi_data = '0;
      st.asi_startofpacket = 0;
      st.asi_endofpacket = 0;
      st.aso_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_asi_ready", st.asi_ready, 0);
      chk("rst_aso_valid", st.aso_valid, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_almost_full", almost_full, 0);
      chk("rst_protocol_error", protocol_error, 0);
      reset = 1'b0;

      // three single-beat packets, one-cycle fall-through
      tv = '{
         '{1, 32'h11, 1, 1, 1, 0, 0},
         '{1, 32'h22, 1, 1, 1, 0, 1},
         '{1, 32'h33, 1, 1, 1, 0, 1},
         '{0, 32'h00, 0, 0, 1, 0, 1},
         '{0, 32'h00, 0, 0, 1, 0, 0}
      };
      run_table("single");

      // fill past full with output stalled, then drain
      for (int k = 0; k < DEPTH + 2; k++)
         step(1, 32'h100 + k, 1, 1, 0);
      chk("full_fill", fill_level, DEPTH);
      chk("full_almost", almost_full, 1);
      chk("full_ready", st.asi_ready, 0);
      drain("full_drain");

      // random traffic, 1000 accepted beats
      sent = 0;
      for (int c = 0; c < 10000 && sent < 1000; c++) begin
         bit v;
         v = 1'($urandom_range(0, 1));
         acc = v && (mcount < DEPTH);
         step(v, $urandom, 1, 1, 1'($urandom_range(0, 1)));
         if (acc) sent++;
      end
      checks++;
      if (sent != 1000) begin
         errors++;
         $display("FAIL random_timeout: sent %0d required 1000", sent);
      end
      drain("random_drain");

`ifdef AVST_PKT_FIFO_STORE_FORWARD_EN
      // slow 4-beat packet held until eop stored
      for (int k = 0; k < 4; k++) begin
         step(1, 32'h200 + k, k == 0, k == 3, 1);
         step(0, '0, 0, 0, 1);
         step(0, '0, 0, 0, 1);
      end
      drain("sf4_drain");
      // 20-beat packet escapes through a full FIFO
      sent = 0;
      for (int c = 0; c < 200 && sent < 20; c++) begin
         acc = mcount < DEPTH;
         step(1, 32'h300 + sent, sent == 0, sent == 19, 1);
         if (acc) sent++;
      end
      checks++;
      if (sent != 20) begin
         errors++;
         $display("FAIL sf20_timeout: sent %0d required 20", sent);
      end
      drain("sf20_drain");
`endif

      // framing violations: no sop, then sop twice
      tv = '{
         '{1, 32'hA, 0, 1, 1, 0, -1},
         '{1, 32'hB, 1, 0, 1, 1, -1},
         '{1, 32'hC, 1, 0, 1, 1, -1},
         '{1, 32'hD, 0, 1, 1, 1, -1},
         '{0, 32'h0, 0, 0, 1, 1, -1}
      };
      run_table("framing");
      drain("framing_drain");
      chk("framing_sticky", protocol_error, 1);

      // reset in the middle of a packet with 5 beats stored
      for (int k = 0; k < 5; k++)
         step(1, 32'h400 + k, k == 0, 0, 0);
      chk("pre_rst_fill", fill_level, 5);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_asi_ready", st.asi_ready, 0);
      chk("mid_rst_aso_valid", st.aso_valid, 0);
      chk("mid_rst_fill", fill_level, 0);
      chk("mid_rst_err", protocol_error, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++)
         step(1, 32'h500 + k, k == 0, k == 2, 1);
      drain("post_rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
